// File: rtl/joystick_adc_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : joystick_adc_sequencer
// Brief   : Alternates XADC DRP reads of the X/Y joystick aux channels on each
//           end-of-conversion and classifies every sample into a direction.
// Revision: 1.0 - initial release
// ============================================================================
module joystick_adc_sequencer #(
    parameter logic [6:0]  ADDR_X    = 7'h16,
    parameter logic [6:0]  ADDR_Y    = 7'h17,
    parameter logic [11:0] LO_THRESH = 12'h300,
    parameter logic [11:0] HI_THRESH = 12'h400,
    parameter int          TIMEOUT   = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_eoc,
    input  logic        i_drdy,
    input  logic [15:0] i_do,
    input  logic        i_clr_err,
    output logic [6:0]  o_daddr,
    output logic        o_den,
    output logic [1:0]  o_x_dir,
    output logic [1:0]  o_y_dir,
    output logic [11:0] o_x_raw,
    output logic [11:0] o_y_raw,
    output logic        o_pair_valid,
    output logic        o_timeout
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

    localparam logic [1:0] C_DIR_NONE = 2'd0;
    localparam logic [1:0] C_DIR_POS  = 2'd1;
    localparam logic [1:0] C_DIR_NEG  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_den_next;
    logic             w_capture;
    logic             w_timeout_hit;
    logic             r_axis;        // 0 = X, 1 = Y
    logic             r_den;
    logic [1:0]       r_x_dir;
    logic [1:0]       r_y_dir;
    logic [11:0]      r_x_raw;
    logic [11:0]      r_y_raw;
    logic             r_pair_valid;
    logic             r_timeout;
    logic [11:0]      w_sample;
    logic             w_unused_do;

    assign w_sample    = i_do[15:4];
    assign w_unused_do = ^i_do[3:0];

    function automatic logic [1:0] classify(input logic [11:0] s);
        if (s < LO_THRESH)
            return C_DIR_NEG;
        else if (s > HI_THRESH)
            return C_DIR_POS;
        else
            return C_DIR_NONE;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_cnt_next    = r_cnt;
        w_den_next    = 1'b0;
        w_capture     = 1'b0;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_eoc) begin
                    w_next     = S_ISSUE;
                    w_den_next = 1'b1;
                end
            end
            S_ISSUE: begin
                w_next     = S_WAIT;
                w_cnt_next = '0;
            end
            S_WAIT: begin
                // A strobe on the final count still wins over the timeout.
                if (i_drdy) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_cnt == C_TIMEOUT) begin
                    w_timeout_hit = 1'b1;
                    w_next        = S_IDLE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_axis       <= 1'b0;
            r_den        <= 1'b0;
            r_x_dir      <= C_DIR_NONE;
            r_y_dir      <= C_DIR_NONE;
            r_x_raw      <= '0;
            r_y_raw      <= '0;
            r_pair_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_den        <= w_den_next;
            r_pair_valid <= w_capture & r_axis;
            if (w_capture) begin
                r_axis <= ~r_axis;
                if (r_axis) begin
                    r_y_raw <= w_sample;
                    r_y_dir <= classify(w_sample);
                end else begin
                    r_x_raw <= w_sample;
                    r_x_dir <= classify(w_sample);
                end
            end
            if (w_timeout_hit)
                r_timeout <= 1'b1;
            else if (i_clr_err)
                r_timeout <= 1'b0;
        end
    end

    assign o_daddr      = r_axis ? ADDR_Y : ADDR_X;
    assign o_den        = r_den;
    assign o_x_dir      = r_x_dir;
    assign o_y_dir      = r_y_dir;
    assign o_x_raw      = r_x_raw;
    assign o_y_raw      = r_y_raw;
    assign o_pair_valid = r_pair_valid;
    assign o_timeout    = r_timeout;

endmodule
`default_nettype wire

// File: doc/joystick_adc_sequencer.md
JOYSTICK_ADC_SEQUENCER -- requirements
Module: joystick_adc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_X, default 7'h16, DRP address of the X-axis aux channel.
REQ-002 SHALL have parameter ADDR_Y, default 7'h17, DRP address of the Y-axis aux channel.
REQ-003 SHALL have parameter LO_THRESH, default 12'h300; samples below it classify as negative.
REQ-004 SHALL have parameter HI_THRESH, default 12'h400; samples above it classify as positive.
REQ-005 SHALL have parameter TIMEOUT, default 255, the maximum number of WAIT cycles before a DRP read is abandoned.
REQ-006 SHALL have port i_clk, input, 1, the single clock (100 MHz DRP clock).
REQ-007 SHALL have port i_rst, input, 1, with asynchronous assertion, active-high.
REQ-008 SHALL have port i_eoc, input, 1, the XADC end-of-conversion pulse.
REQ-009 SHALL have port i_drdy, input, 1, the DRP data-ready strobe.
REQ-010 SHALL have port i_do, input, 16, the DRP read data; the 12-bit sample is i_do[15:4].
REQ-011 SHALL have port i_clr_err, input, 1, a synchronous clear for o_timeout.
REQ-012 SHALL have port o_daddr, output, 7, the DRP address.
REQ-013 SHALL have port o_den, output, 1, the DRP enable, registered.
REQ-014 SHALL have port o_x_dir, output, 2, the X direction: 0 none, 1 positive, 2 negative (3 never driven).
REQ-015 SHALL have port o_y_dir, output, 2, the Y direction, using the same encoding as o_x_dir.
REQ-016 SHALL have port o_x_raw, output, 12, the last X sample.
REQ-017 SHALL have port o_y_raw, output, 12, the last Y sample.
REQ-018 SHALL have port o_pair_valid, output, 1, a one-cycle pulse emitted after each completed Y read.
REQ-019 SHALL have port o_timeout, output, 1, a sticky DRP timeout flag.

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE and WAIT, plus an axis register (X or Y).
REQ-021 SHALL drive o_daddr = ADDR_X when the axis register is X and ADDR_Y when it is Y, at all times.
REQ-022 IDLE SHALL move to ISSUE on i_eoc=1 and stay in IDLE otherwise.
REQ-023 ISSUE SHALL assert o_den for exactly one cycle, then enter WAIT with the wait counter at 0.
REQ-024 Eoc-to-den latency SHALL be 1 cycle (i_eoc high in cycle n gives o_den high in cycle n+1).
REQ-025 Each WAIT cycle with i_drdy=0 SHALL increment the wait counter.
REQ-026 WAIT with i_drdy=0 and the wait counter equal to TIMEOUT SHALL set o_timeout, go to IDLE and leave the axis unchanged.
REQ-027 WAIT with i_drdy=1 SHALL capture i_do[15:4] into the raw register for the current axis, update that axis's direction, toggle the axis and go to IDLE.
REQ-028 Updates from REQ-027 SHALL be visible in the cycle after i_drdy.
REQ-029 Classification SHALL be an unsigned compare: sample < LO_THRESH gives 2, sample > HI_THRESH gives 1, otherwise 0; both thresholds are inclusive to the none band.
REQ-030 o_pair_valid SHALL pulse for 1 cycle, coincident with the update from REQ-028, only when the completed read was for Y.
REQ-031 i_eoc SHALL be ignored in ISSUE and WAIT, with no queuing.
REQ-032 i_drdy SHALL be ignored in IDLE and ISSUE.
REQ-033 i_drdy=1 in the same cycle the timeout count is reached SHALL take priority: the sample is taken and o_timeout is not set.
REQ-034 i_clr_err SHALL clear o_timeout on the next edge; if a timeout and i_clr_err coincide, the set wins.
REQ-035 o_den SHALL never be high in two consecutive cycles, and SHALL never be high in WAIT.

Reset
REQ-036 On i_rst: state IDLE, axis X, o_daddr=ADDR_X, o_den=0, o_x_dir=o_y_dir=0, o_x_raw=o_y_raw=0, o_pair_valid=0, o_timeout=0, wait counter 0.
REQ-037 An i_rst asserted mid-WAIT SHALL abort the read; a later i_drdy in IDLE SHALL be ignored.
REQ-038 Reset release SHALL be synchronous to i_clk; the first i_eoc after release SHALL read X.

Verification
REQ-039 Nominal: eoc, drdy 3 cycles after den with i_do=16'h8000 -> o_x_raw=12'h800 and o_x_dir=1; next eoc, i_do=16'h1000 -> o_y_dir=2 and o_pair_valid pulses once.
REQ-040 Boundaries: samples 12'h300 and 12'h400 -> dir 0; 12'h2FF -> 2; 12'h401 -> 1.
REQ-041 Timeout: den issued, no drdy for TIMEOUT+1 cycles -> o_timeout=1, next read still uses ADDR_X; assert i_clr_err -> o_timeout=0.
REQ-042 Collision: drdy on the exact timeout cycle -> sample captured, o_timeout stays 0.
REQ-043 Ignored events: eoc during WAIT -> no extra den; drdy while IDLE -> no register change.
REQ-044 Reset mid-WAIT -> all outputs return to their reset values; the following eoc issues den with o_daddr=7'h16.
